// File: rtl/inpass_config_sequencer_pkg.sv
// Shared types and helpers for the InPass4 configuration sequencer.
package inpass_cfg_pkg;

  // Sequencer states; the encoding is fixed so it can be read off a probe.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    COMMIT = 2'd2,
    SETTLE = 2'd3
  } state_e;

  // Width of the settle counter; holds SettleCycles-1 for SettleCycles up to 15.
  localparam int CNT_W = 4;

  // Index width for a column of num_bels BELs, never narrower than one bit.
  function automatic int calc_iw(input int num_bels);
    return (num_bels > 1) ? $clog2(num_bels) : 1;
  endfunction

endpackage

// File: rtl/inpass_config_sequencer_if.sv
// Valid/ready stream carrying per-BEL mode words into the sequencer.
interface inpass_config_sequencer_if #(
  parameter int NumBels      = 8,
  parameter int NoConfigBits = 4
);
  localparam int IW = inpass_cfg_pkg::calc_iw(NumBels);

  logic                    cfg_valid;
  logic                    cfg_ready;
  logic [IW-1:0]           cfg_index;
  logic [NoConfigBits-1:0] cfg_bits;

  // Fabric-side control logic presents words.
  modport master (
    output cfg_valid,
    output cfg_index,
    output cfg_bits,
    input  cfg_ready
  );

  // The sequencer consumes words.
  modport slave (
    input  cfg_valid,
    input  cfg_index,
    input  cfg_bits,
    output cfg_ready
  );
endinterface

// File: rtl/inpass_config_sequencer_shadow_bank.sv
// Shadow register array holding staged mode words, one slot per BEL.
module inpass_shadow_bank
  import inpass_cfg_pkg::*;
#(
  parameter int NumBels      = 8,
  parameter int NoConfigBits = 4,
  parameter int IW           = 3
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            wr_en,
  input  logic [IW-1:0]                   wr_index,
  input  logic [NoConfigBits-1:0]         wr_bits,
  output logic [NumBels*NoConfigBits-1:0] shadow_flat,
  output logic [NumBels*NoConfigBits-1:0] shadow_next_flat
);

  logic [NoConfigBits-1:0] shadow_q [NumBels];
  logic [NoConfigBits-1:0] shadow_d [NumBels];

  // Indexed write port: only the addressed slot takes the new word.
  always_comb begin
    for (int i = 0; i < NumBels; i++) begin
      shadow_d[i] = shadow_q[i];
      if (wr_en && (wr_index == IW'(i))) begin
        shadow_d[i] = wr_bits;
      end
    end
  end

  // Flatten current and next contents in BEL order for the live register.
  always_comb begin
    shadow_flat      = '0;
    shadow_next_flat = '0;
    for (int i = 0; i < NumBels; i++) begin
      shadow_flat[i*NoConfigBits +: NoConfigBits]      = shadow_q[i];
      shadow_next_flat[i*NoConfigBits +: NoConfigBits] = shadow_d[i];
    end
  end

  // Shadow storage; reset returns every BEL to combinational pass-through.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NumBels; i++) begin
        shadow_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NumBels; i++) begin
        shadow_q[i] <= shadow_d[i];
      end
    end
  end

endmodule

// File: rtl/inpass_config_sequencer.sv
// Stages per-BEL InPass4 mode words and applies them all on one edge at commit.
module inpass_config_sequencer
  import inpass_cfg_pkg::*;
#(
  parameter int  NumBels      = 8,
  parameter int  NoConfigBits = 4,
  parameter int  SettleCycles = 2,
  localparam int IW           = calc_iw(NumBels),
  localparam int BW           = NumBels * NoConfigBits
) (
  input  logic                       UserCLK,
  input  logic                       resetn,
  inpass_config_sequencer_if.slave   cfg_if,
  input  logic                       commit,
  output logic [BW-1:0]              ConfigBits,
  output logic                       busy,
  output logic                       pending,
  output logic                       err_index,
  output logic [IW:0]                word_count
);

  localparam logic [IW:0]      NUM_BELS_W  = (IW+1)'(NumBels);
  localparam logic [IW:0]      WC_MAX      = '1;
  localparam logic [IW:0]      WC_ONE      = (IW+1)'(1);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
  localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SettleCycles - 1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  settle_cnt_q, settle_cnt_d;
  logic [BW-1:0]     config_q, config_d;
  logic [IW:0]       word_count_q, word_count_d;
  logic              err_index_q, err_index_d;
  logic              pending_q, pending_d;

  logic [BW-1:0]     shadow_flat;
  logic [BW-1:0]     shadow_next_flat;
  logic              accept;
  logic              handshake;
  logic              index_ok;
  logic              wr_en;
  logic              bad_index;

  // Accept words only while not committing or settling; decoded from state.
  assign accept           = (state_q == IDLE) || (state_q == LOAD);
  assign cfg_if.cfg_ready = accept;
  assign busy             = (state_q == COMMIT) || (state_q == SETTLE);

  // Classify the handshake as a real write or an out-of-range word to drop.
  assign handshake = cfg_if.cfg_valid && accept;
  assign index_ok  = ({1'b0, cfg_if.cfg_index} < NUM_BELS_W);
  assign wr_en     = handshake && index_ok;
  assign bad_index = handshake && !index_ok;

  inpass_shadow_bank #(
    .NumBels      (NumBels),
    .NoConfigBits (NoConfigBits),
    .IW           (IW)
  ) u_shadow_bank (
    .clk              (UserCLK),
    .rst_n            (resetn),
    .wr_en            (wr_en),
    .wr_index         (cfg_if.cfg_index),
    .wr_bits          (cfg_if.cfg_bits),
    .shadow_flat      (shadow_flat),
    .shadow_next_flat (shadow_next_flat)
  );

  // Next-state logic for the sequencer, live register, counters and flags.
  always_comb begin
    state_d      = state_q;
    settle_cnt_d = settle_cnt_q;
    config_d     = config_q;
    word_count_d = word_count_q;
    err_index_d  = err_index_q;

    case (state_q)
      IDLE, LOAD: begin
        if (wr_en && (word_count_q != WC_MAX)) begin
          word_count_d = word_count_q + WC_ONE;
        end
        if (bad_index) begin
          err_index_d = 1'b1;
        end
        if (commit) begin
          state_d = COMMIT;
        end else if (wr_en) begin
          state_d = LOAD;
        end
      end
      COMMIT: begin
        config_d     = shadow_flat;
        word_count_d = '0;
        err_index_d  = 1'b0;
        settle_cnt_d = SETTLE_LOAD;
        state_d      = SETTLE;
      end
      SETTLE: begin
        if (settle_cnt_q == '0) begin
          state_d = IDLE;
        end else begin
          settle_cnt_d = settle_cnt_q - CNT_ONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    pending_d = (shadow_next_flat != config_d) || (word_count_d != '0);
  end

  // State and output registers; reset clears everything at once, even mid-settle.
  always_ff @(posedge UserCLK or negedge resetn) begin
    if (!resetn) begin
      state_q      <= IDLE;
      settle_cnt_q <= '0;
      config_q     <= '0;
      word_count_q <= '0;
      err_index_q  <= 1'b0;
      pending_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      settle_cnt_q <= settle_cnt_d;
      config_q     <= config_d;
      word_count_q <= word_count_d;
      err_index_q  <= err_index_d;
      pending_q    <= pending_d;
    end
  end

  assign ConfigBits = config_q;
  assign word_count = word_count_q;
  assign err_index  = err_index_q;
  assign pending    = pending_q;

endmodule
